load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MAX_WAIT, 255, max ACCESS-state cycles without i_dmem_ack before fault (1..255).
REQ-002 i_clk  in  1  sole clock, rising edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_valid  in  1  execute stage presents a memory op this cycle.
REQ-005 o_ready  out  1  unit can accept; high iff state IDLE.
REQ-006 i_load, i_store  in  1 each  op kind; load wins if both set.
REQ-007 i_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 i_addr  in  32  effective address (ALU result).
REQ-009 i_wdata  in  32  store data (rs2).
REQ-010 o_dmem_req, o_dmem_we  out  1 each  memory request, write enable.
REQ-011 o_dmem_addr  out  32  word address, bits [1:0] = 0.
REQ-012 o_dmem_wdata  out  32; o_dmem_mask  out  4  lane data and byte enables.
REQ-013 i_dmem_ack  in  1; i_dmem_rdata  in  32  memory completion, read word.
REQ-014 o_done  out  1  one-cycle completion pulse; o_rdata  out  32  extended load result.
REQ-015 o_misaligned, o_fault  out  1 each  qualify o_done.

Function
REQ-016 States IDLE, ACCESS, RESP; accept when i_valid && o_ready && (i_load || i_store); otherwise stay IDLE.
REQ-017 Accept cycle N: latch addr, funct3, kind, lane data, mask; ACCESS from N+1.
REQ-018 ACCESS: o_dmem_req=1, all request outputs stable until ack; i_dmem_ack in ACCESS -> RESP next cycle.
REQ-019 RESP lasts exactly one cycle: o_done=1, then IDLE; earliest turnaround accept N, ack N+1, done N+2, accept again N+3.
REQ-020 Wait counter clears on accept, increments each ACCESS cycle without ack; counter==MAX_WAIT -> drop req, RESP with o_fault=1, o_rdata=0.
REQ-021 Ack and timeout in same cycle: ack wins, o_fault=0.
REQ-022 i_dmem_ack outside ACCESS is ignored.
REQ-023 Store lanes: B replicates byte x4, mask 0001<<addr[1:0]; H replicates half x2, mask 0011<<(2*addr[1]); W mask 1111; loads mask 1111, we=0.
REQ-024 Load: select byte/half by latched addr, sign-extend for 000/001, zero-extend for 100/101; read word captured on ack cycle.
REQ-025 Stores: o_rdata=0 at o_done; o_rdata/o_misaligned/o_fault are 0 whenever o_done=0.

Reset
REQ-026 Reset -> IDLE, counter 0, o_dmem_req/we/done/misaligned/fault 0, addr/wdata/mask/rdata 0, o_ready 1 after the reset edge.
REQ-027 Reset during ACCESS drops o_dmem_req at that edge, no o_done is produced.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 issues no request, goes RESP next cycle with o_done=1, o_misaligned=1, o_rdata=0.
REQ-029 Macro undefined: misaligned offset bits forced to 0 (H ignores addr[0], W ignores addr[1:0]); o_misaligned tied 0.

Structure
REQ-030 Shared package lsu_pkg: funct3 constants, state enum, MAX_WAIT default.
REQ-031 Combinational sub-module lsu_align: store lane replicate/mask and load select/extend; FSM and counter stay in load_store_unit.

Verification
REQ-032 SW addr 0x104 data 0xDEADBEEF, ack 1 cycle -> dmem_addr 0x104, mask 1111, wdata 0xDEADBEEF, done 2 cycles after accept.
REQ-033 LB addr 0x203, rdata 0x80000000 -> o_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 SH addr 0x302 data 0x0000ABCD -> mask 1100, wdata 0xABCDABCD.
REQ-035 LW, no ack, MAX_WAIT=4 -> req high 4 cycles, o_done+o_fault, rdata 0, o_ready next cycle.
REQ-036 LW addr 0x101 with macro -> no req, done+misaligned next cycle; without macro -> dmem_addr 0x100, normal load.
REQ-037 Reset asserted during ACCESS -> req 0 after edge, no done, o_ready 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encoding and the default access timeout.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MAX_WAIT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: replicates store data across
// the word and builds the byte mask, and selects/extends load results from
// the returned word. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_mask,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store: replicate the narrow datum into every lane, enable only the target lane(s)
    always_comb begin
        st_data = st_wdata;
        st_mask = 4'b1111;
        case (st_funct3)
            F3_B: begin
                st_data = {4{st_wdata[7:0]}};
                st_mask = 4'b0001 << st_off;
            end
            F3_H: begin
                st_data = {2{st_wdata[15:0]}};
                st_mask = st_off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load: pick the addressed byte/half from the read word and extend it
    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from execute, issues a single
// word-aligned data-memory request, waits for ack (bounded by MAX_WAIT) and
// returns a one-cycle completion pulse with the extended load result.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are not
// issued and complete with o_misaligned instead of being silently aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_fault
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    lsu_state_e  state;
    logic [7:0]  wait_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_load_q;
    logic [1:0]  eff_off;
    logic        misalign_trap;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic [31:0] ld_data;

    assign o_ready = (state == ST_IDLE);

    // Lane offset actually used: halves and words drop their misaligned offset bits
    always_comb begin
        eff_off = i_addr[1:0];
        case (i_funct3)
            F3_H, F3_HU: eff_off[0] = 1'b0;
            F3_W:        eff_off    = 2'b00;
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Flag accesses whose address is not naturally aligned for their width
    always_comb begin
        case (i_funct3)
            F3_H, F3_HU: misalign_trap = i_addr[0];
            F3_W:        misalign_trap = |i_addr[1:0];
            default:     misalign_trap = 1'b0;
        endcase
    end
`else
    assign misalign_trap = 1'b0;
`endif

    lsu_align u_align (
        .st_funct3 (i_funct3),
        .st_off    (eff_off),
        .st_wdata  (i_wdata),
        .st_data   (st_data),
        .st_mask   (st_mask),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .ld_word   (i_dmem_rdata),
        .ld_data   (ld_data)
    );

    // Request FSM with wait counter; all outputs registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= 8'd0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            is_load_q    <= 1'b0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'd0;
            o_dmem_wdata <= 32'd0;
            o_dmem_mask  <= 4'd0;
            o_done       <= 1'b0;
            o_rdata      <= 32'd0;
            o_misaligned <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            // Completion qualifiers are only meaningful for the single RESP cycle
            o_done       <= 1'b0;
            o_rdata      <= 32'd0;
            o_misaligned <= 1'b0;
            o_fault      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_valid && (i_load || i_store)) begin
                        f3_q         <= i_funct3;
                        off_q        <= eff_off;
                        is_load_q    <= i_load;
                        wait_cnt     <= 8'd0;
                        o_dmem_addr  <= {i_addr[31:2], 2'b00};
                        o_dmem_wdata <= i_load ? 32'd0 : st_data;
                        o_dmem_mask  <= i_load ? 4'b1111 : st_mask;
                        if (misalign_trap) begin
                            state        <= ST_RESP;
                            o_done       <= 1'b1;
                            o_misaligned <= 1'b1;
                        end else begin
                            state      <= ST_ACCESS;
                            o_dmem_req <= 1'b1;
                            o_dmem_we  <= ~i_load;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ack takes priority over a timeout landing in the same cycle
                    if (i_dmem_ack) begin
                        state      <= ST_RESP;
                        o_dmem_req <= 1'b0;
                        o_dmem_we  <= 1'b0;
                        o_done     <= 1'b1;
                        o_rdata    <= is_load_q ? ld_data : 32'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= ST_RESP;
                        o_dmem_req <= 1'b0;
                        o_dmem_we  <= 1'b0;
                        o_done     <= 1'b1;
                        o_fault    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level
// reference model. Honors LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MW = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_misaligned;
    logic        o_fault;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.MAX_WAIT(MW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_load       (i_load),
        .i_store      (i_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_mask  (o_dmem_mask),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned),
        .o_fault      (o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: value a load of this width/offset returns from a memory word
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (f3)
            3'b000:  return 32'($signed(sh[7:0]));
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return 32'($signed(sh[15:0]));
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // One full transaction starting at a negedge in IDLE; returns at the
    // negedge of the first cycle the unit is ready again.
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_dly, input logic [31:0] word);
        int          off;
        int          size;
        logic        trap;
        logic [31:0] ew;
        logic [3:0]  em;
        logic [31:0] er;
        logic        eff_store;

        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(addr[1:0]);
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (off % size) != 0;
`endif
        off = off - (off % size);
        eff_store = st && !ld;
        case (size)
            1:       begin ew = {4{wd[7:0]}};  em = 4'(1 << off); end
            2:       begin ew = {2{wd[15:0]}}; em = 4'(3 << off); end
            default: begin ew = wd;            em = 4'hF;         end
        endcase
        if (!eff_store) em = 4'hF;
        er = eff_store ? 32'd0 : ref_load(f3, off, word);

        chk("ready_idle", 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_load = ld; i_store = st; i_funct3 = f3;
        i_addr = addr; i_wdata = wd;
        @(negedge i_clk);
        // Scramble execute inputs: the in-flight request must not follow them
        i_addr = $urandom; i_wdata = $urandom; i_funct3 = 3'($urandom);
        if (!ld && !st) begin
            chk("noop_req", 32'(o_dmem_req), 32'd0);
            chk("noop_ready", 32'(o_ready), 32'd1);
            i_valid = 1'b0;
            return;
        end
        if (trap) begin
            chk("trap_done", 32'(o_done), 32'd1);
            chk("trap_mis", 32'(o_misaligned), 32'd1);
            chk("trap_req", 32'(o_dmem_req), 32'd0);
            chk("trap_fault", 32'(o_fault), 32'd0);
            chk("trap_rdata", o_rdata, 32'd0);
        end else begin
            for (int k = 0; k < MW; k++) begin
                chk("acc_req", 32'(o_dmem_req), 32'd1);
                chk("acc_we", 32'(o_dmem_we), 32'(eff_store));
                chk("acc_addr", o_dmem_addr, {addr[31:2], 2'b00});
                chk("acc_mask", 32'(o_dmem_mask), 32'(em));
                if (eff_store) chk("acc_wdata", o_dmem_wdata, ew);
                chk("acc_done", 32'(o_done), 32'd0);
                chk("acc_ready", 32'(o_ready), 32'd0);
                if (k == ack_dly) begin
                    i_dmem_ack = 1'b1; i_dmem_rdata = word;
                    @(negedge i_clk);
                    i_dmem_ack = 1'b0; i_dmem_rdata = $urandom;
                    chk("ack_done", 32'(o_done), 32'd1);
                    chk("ack_fault", 32'(o_fault), 32'd0);
                    chk("ack_mis", 32'(o_misaligned), 32'd0);
                    chk("ack_rdata", o_rdata, er);
                    chk("ack_req", 32'(o_dmem_req), 32'd0);
                    break;
                end
                if (k == MW - 1) begin
                    @(negedge i_clk);
                    chk("to_done", 32'(o_done), 32'd1);
                    chk("to_fault", 32'(o_fault), 32'd1);
                    chk("to_rdata", o_rdata, 32'd0);
                    chk("to_req", 32'(o_dmem_req), 32'd0);
                    break;
                end
                @(negedge i_clk);
            end
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("post_ready", 32'(o_ready), 32'd1);
        chk("post_done", 32'(o_done), 32'd0);
        chk("post_rdata", o_rdata, 32'd0);
        chk("post_fault", 32'(o_fault), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3s [5];
        logic [2:0] f3;
        int         kind;
        f3s[0] = F3_B; f3s[1] = F3_H; f3s[2] = F3_W; f3s[3] = F3_BU; f3s[4] = F3_HU;

        i_rst = 1'b1; i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
        i_funct3 = 3'd0; i_addr = 32'd0; i_wdata = 32'd0;
        i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
        repeat (2) @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_req", 32'(o_dmem_req), 32'd0);
        chk("rst_we", 32'(o_dmem_we), 32'd0);
        chk("rst_addr", o_dmem_addr, 32'd0);
        chk("rst_wdata", o_dmem_wdata, 32'd0);
        chk("rst_mask", 32'(o_dmem_mask), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_mis", 32'(o_misaligned), 32'd0);
        chk("rst_fault", 32'(o_fault), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Directed cases
        do_op(1'b0, 1'b1, F3_W,  32'h0000_0104, 32'hDEADBEEF, 0, 32'd0);
        do_op(1'b1, 1'b0, F3_B,  32'h0000_0203, 32'd0, 0, 32'h8000_0000);
        do_op(1'b1, 1'b0, F3_BU, 32'h0000_0203, 32'd0, 1, 32'h8000_0000);
        do_op(1'b0, 1'b1, F3_H,  32'h0000_0302, 32'h0000_ABCD, 2, 32'd0);
        do_op(1'b1, 1'b0, F3_W,  32'h0000_0100, 32'd0, 99, 32'd0);
        do_op(1'b1, 1'b0, F3_W,  32'h0000_0101, 32'd0, 0, 32'h1234_5678);
        do_op(1'b1, 1'b0, F3_HU, 32'h0000_0043, 32'd0, MW - 1, 32'hFEDC_BA98);
        do_op(1'b1, 1'b1, F3_H,  32'h0000_0012, 32'h0000_5555, 0, 32'h8001_7FFF);

        // Ack while idle must be ignored
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge i_clk);
            chk("idle_ack_done", 32'(o_done), 32'd0);
            chk("idle_ack_ready", 32'(o_ready), 32'd1);
        end
        i_dmem_ack = 1'b0;

        // Reset in the middle of an access
        i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = F3_W; i_addr = 32'h40;
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("mid_req", 32'(o_dmem_req), 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_req", 32'(o_dmem_req), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        i_rst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("mid_after_done", 32'(o_done), 32'd0);
            chk("mid_after_req", 32'(o_dmem_req), 32'd0);
        end

        // Randomized traffic, back to back
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 7);
            f3 = (kind[0] == 1'b0 && kind < 6) ? f3s[$urandom_range(0, 2)] : f3s[$urandom_range(0, 4)];
            case (kind)
                0, 1, 2: do_op(1'b0, 1'b1, f3s[$urandom_range(0, 2)], $urandom, $urandom,
                               $urandom_range(0, 5), $urandom);
                3, 4, 5: do_op(1'b1, 1'b0, f3, $urandom, $urandom, $urandom_range(0, 5), $urandom);
                6:       do_op(1'b1, 1'b1, f3, $urandom, $urandom, $urandom_range(0, 5), $urandom);
                default: do_op(1'b0, 1'b0, f3, $urandom, $urandom, 0, $urandom);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
